if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage; it is the producer side of the IF/ID pipeline register.
- Holds the PC and issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake.
- Presents if_pc/if_inst for IF/ID to capture, and raises stallreq_if to the control unit while no instruction is ready.
- Accepts branch/jump redirects and discards any fetch that is in flight or buffered at that moment.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC/address width (matches `ADDR_WIDTH`).
- INST_W, 32, instruction width (matches `INST_WIDTH`).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  reset; synchronous, active-high.
- stall  in  6  control-unit stall vector; only stall[1] is used (1 = IF/ID will not capture this cycle).
- jmp_flag  in  1  redirect request from the execute stage.
- jmp_target  in  ADDR_W  redirect PC; bits [1:0] are ignored and forced to 0.
- mem_req  out  1  fetch request.
- mem_addr  out  ADDR_W  fetch address, word-aligned.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  INST_W  instruction word.
- if_pc  out  ADDR_W  PC of the presented instruction; ZeroWord if none.
- if_inst  out  INST_W  presented instruction; ZeroWord (bubble) if none.
- stallreq_if  out  1  stall request to the control unit.

Behaviour:
- Reset (synchronous): pc=RESET_PC, state=IDLE, kill=0, if_pc=0, if_inst=0. Combinational outputs follow state: mem_req=1 in IDLE unless jmp_flag, stallreq_if=1.
- States: IDLE (issue), WAIT (request granted, awaiting data), READY (instruction held on outputs).
- stallreq_if = (state != READY).
- IDLE:
  - mem_req=1, mem_addr=pc; req/addr are held stable until mem_gnt.
  - gnt -> WAIT.
  - mem_rvalid in IDLE is ignored.
- WAIT:
  - mem_req=0.
  - On rvalid with kill=0 -> if_pc<=pc, if_inst<=mem_rdata, go to READY.
  - On rvalid with kill=1 -> drop the data, kill<=0, go to IDLE.
- READY:
  - Outputs hold their values while stall[1]=1.
  - At an edge with stall[1]=0 the instruction is consumed by IF/ID: pc<=pc+4 (modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0), if_pc/if_inst<=ZeroWord, go to IDLE.
- Redirect: jmp_flag has priority over every other event and is independent of stall. pc<=jmp_target&~3.
  - IDLE: mem_req is forced to 0 that cycle; stay IDLE; the next cycle requests the target.
  - WAIT without rvalid: kill<=1; stay WAIT.
  - WAIT with rvalid in the same cycle: drop the data; go to IDLE; kill stays 0.
  - READY: if_pc/if_inst<=ZeroWord; go to IDLE.
  - A second jmp_flag while kill=1 only updates pc.
- Single-outstanding rule: the memory never asserts rvalid in the same cycle as gnt. The minimum latency is 1 cycle after gnt.
- Minimum throughput: 3 cycles per instruction (IDLE, WAIT, READY).
- RST asserted mid-operation aborts immediately. Any later stray rvalid arrives in IDLE and is ignored.

Optional Feature:
- Macro: IF_FETCH_PREFETCH_EN.
- Defined: in READY with stall[1]=0 and jmp_flag=0, mem_req=1 and mem_addr=pc+4 in the same cycle.
  - gnt -> pc<=pc+4 and go directly to WAIT.
  - no gnt -> IDLE as normal.
  - Throughput becomes 2 cycles per instruction.
- Undefined: mem_req=0 in READY; behaviour as above.

Decomposition:
- Shared config header: ADDR_WIDTH, INST_WIDTH, ZeroWord, and the state encodings FETCH_IDLE/FETCH_WAIT/FETCH_READY.
- No sub-module; single flat module with a state register, the kill flag, and the output registers.

Test Plan:
- Reset with RESET_PC=0; gnt is immediate; rvalid arrives 1 cycle after gnt with rdata=32'h00000013; stall=0 -> if_pc=0, if_inst=32'h13 held for exactly 1 cycle; next request addr=4; stallreq_if low only in READY.
- READY with stall[1]=1 for 5 cycles -> if_pc/if_inst are stable and pc is not incremented; release -> next mem_addr=pc+4.
- jmp_flag in WAIT with jmp_target=32'h103 and rvalid 3 cycles later -> rdata is dropped (if_inst stays 0); next mem_addr=32'h100.
- jmp_flag coincident with rvalid -> data dropped, kill remains 0; the next fetch at the target is presented normally.
- pc=32'hFFFF_FFFC consumed -> next mem_addr=0; RST asserted while in WAIT, then a stray rvalid -> ignored, fetch restarts at RESET_PC.
- With IF_FETCH_PREFETCH_EN, gnt and rvalid both 1-cycle -> a new instruction every 2 cycles; mem_addr sequence 0, 4, 8.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared configuration for the instruction-fetch stage.
//   ADDR_WIDTH / INST_WIDTH : default PC and instruction widths
//   ZeroWord                : bubble value driven on if_pc/if_inst when empty
//   FETCH_IDLE/WAIT/READY   : fetch FSM state encodings
package if_fetch_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned INST_WIDTH = 32;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam logic [1:0] FETCH_IDLE  = 2'd0;  // issue request for pc
  localparam logic [1:0] FETCH_WAIT  = 2'd1;  // granted, awaiting rvalid
  localparam logic [1:0] FETCH_READY = 2'd2;  // instruction held on outputs

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: producer side of the IF/ID pipeline register.
// Holds the PC, issues single-outstanding req/gnt/rvalid fetches, presents the
// fetched instruction on if_pc/if_inst and stalls the pipe while none is ready.
// Branch/jump redirects discard any fetch in flight or held at that moment.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   stall[5:0]        control-unit stall vector; only stall[1] (IF/ID hold) used
//   jmp_flag          redirect request, overrides every other event
//   jmp_target        redirect PC, low two bits forced to zero
//   mem_req/mem_addr  fetch request and word-aligned address
//   mem_gnt           request accepted this cycle
//   mem_rvalid/rdata  read data return
//   if_pc/if_inst     presented instruction, ZeroWord when none
//   stallreq_if       high whenever no instruction is presented
//
// Build option: define IF_FETCH_PREFETCH_EN to issue the next fetch (pc+4) in
// the same cycle an instruction is consumed, giving 2 cycles per instruction.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_WIDTH,
  parameter int unsigned       INST_W   = INST_WIDTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [5:0]        stall,
  input  logic              jmp_flag,
  input  logic [ADDR_W-1:0] jmp_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [INST_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic              stallreq_if
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              kill_q, kill_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [INST_W-1:0] if_inst_q, if_inst_d;

  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] jmp_pc;
  logic              consume;

  // Only the IF/ID hold bit of the stall vector matters here.
  logic unused_stall;
  assign unused_stall = ^{stall[5:2], stall[0]};

  assign pc_next = pc_q + ADDR_W'(4);  // wraps modulo 2^ADDR_W
  assign jmp_pc  = {jmp_target[ADDR_W-1:2], 2'b00};
  assign consume = (state_q == FETCH_READY) && !stall[1] && !jmp_flag;

  // Memory request side
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = pc_q;
    if (state_q == FETCH_IDLE) begin
      mem_req = !jmp_flag;
    end
`ifdef IF_FETCH_PREFETCH_EN
    if (consume) begin
      mem_req  = 1'b1;
      mem_addr = pc_next;
    end
`endif
  end

  assign stallreq_if = (state_q != FETCH_READY);
  assign if_pc       = if_pc_q;
  assign if_inst     = if_inst_q;

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    kill_d    = kill_q;
    if_pc_d   = if_pc_q;
    if_inst_d = if_inst_q;

    if (jmp_flag) begin
      pc_d = jmp_pc;
      case (state_q)
        FETCH_WAIT: begin
          if (mem_rvalid) begin
            // Data arriving with the redirect is stale; nothing left to kill.
            state_d = FETCH_IDLE;
            kill_d  = 1'b0;
          end else begin
            kill_d = 1'b1;
          end
        end
        FETCH_READY: begin
          state_d   = FETCH_IDLE;
          if_pc_d   = ADDR_W'(ZeroWord);
          if_inst_d = INST_W'(ZeroWord);
        end
        default: state_d = FETCH_IDLE;
      endcase
    end else begin
      case (state_q)
        FETCH_IDLE: begin
          if (mem_gnt) state_d = FETCH_WAIT;
        end
        FETCH_WAIT: begin
          if (mem_rvalid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = FETCH_IDLE;
            end else begin
              if_pc_d   = pc_q;
              if_inst_d = mem_rdata;
              state_d   = FETCH_READY;
            end
          end
        end
        FETCH_READY: begin
          if (!stall[1]) begin
            pc_d      = pc_next;
            if_pc_d   = ADDR_W'(ZeroWord);
            if_inst_d = INST_W'(ZeroWord);
            state_d   = FETCH_IDLE;
`ifdef IF_FETCH_PREFETCH_EN
            if (mem_gnt) state_d = FETCH_WAIT;
`endif
          end
        end
        default: state_d = FETCH_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= FETCH_IDLE;
      pc_q      <= RESET_PC;
      kill_q    <= 1'b0;
      if_pc_q   <= ADDR_W'(ZeroWord);
      if_inst_q <= INST_W'(ZeroWord);
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      kill_q    <= kill_d;
      if_pc_q   <= if_pc_d;
      if_inst_q <= if_inst_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: a directed cycle table, a prefetch
// throughput sequence (when IF_FETCH_PREFETCH_EN is defined) and a randomized
// run against a transaction-level model of the expected PC stream.
module tb_if_fetch;

  logic        CLK = 1'b0;
  logic        RST;
  logic [5:0]  stall;
  logic        jmp_flag;
  logic [31:0] jmp_target;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if;

  int n_chk  = 0;
  int n_fail = 0;

  if_fetch #(
    .RESET_PC(32'h0000_0000)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .stall      (stall),
    .jmp_flag   (jmp_flag),
    .jmp_target (jmp_target),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .stallreq_if(stallreq_if)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory image: never zero, so a real instruction is distinguishable from a bubble.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h5A00_0000;
  endfunction

  typedef struct {
    logic        rst, s1, jmp;
    logic [31:0] jt;
    logic        gnt, rv;
    logic [31:0] rd;
    logic        chk, req;
    logic [31:0] addr;
    logic        sreq;
    logic [31:0] ipc, iinst;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, s1, jmp, input logic [31:0] jt,
                              input logic gnt, rv, input logic [31:0] rd,
                              input logic chk, req, input logic [31:0] addr,
                              input logic sreq, input logic [31:0] ipc, iinst);
    vec_t v;
    v.rst = rst; v.s1 = s1; v.jmp = jmp; v.jt = jt; v.gnt = gnt; v.rv = rv; v.rd = rd;
    v.chk = chk; v.req = req; v.addr = addr; v.sreq = sreq; v.ipc = ipc; v.iinst = iinst;
    vecs.push_back(v);
  endfunction

  // Random-phase state
  logic [31:0] exp_pc, out_addr, exp_addr;
  logic        outst;
  int          lat, stuck, presented;

  // Prefetch-sequence records
  logic [31:0] pf_addrs[$];
  int          pf_pres[$];
  logic        pend;
  logic [31:0] pend_addr;

  initial begin
    RST = 1'b1; stall = '0; jmp_flag = 1'b0; jmp_target = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    //  rst s1 jmp jt            gnt rv rd            chk req addr          sreq ipc           iinst
    add(1, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0,         32'h0);
    add(1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 1, 32'h0,         1, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,         1, 0, 32'h0,         1, 1, 32'h0,         1, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,         0, 1, 32'h13,        1, 0, 32'h0,         1, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         32'h13);
    add(0, 0, 0, 32'h0,         1, 0, 32'h0,         1, 1, 32'h4,         1, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,         0, 1, 32'h00400093,  1, 0, 32'h0,         1, 32'h0,         32'h0);
    for (int k = 0; k < 5; k++)
      add(0, 1, 0, 32'h0,       0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h4,         32'h00400093);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h4,         32'h00400093);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 1, 32'h8,         1, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,         1, 0, 32'h0,         1, 1, 32'h8,         1, 32'h0,         32'h0);
    // redirect while waiting; stale data returns 3 cycles later
    add(0, 0, 1, 32'h103,       0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,         0, 1, 32'hDEAD,      1, 0, 32'h0,         1, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 1, 32'h100,       1, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,         1, 0, 32'h0,         1, 1, 32'h100,       1, 32'h0,         32'h0);
    // redirect coincident with rvalid
    add(0, 0, 1, 32'h200,       0, 1, 32'hBAD,       1, 0, 32'h0,         1, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,         1, 0, 32'h0,         1, 1, 32'h200,       1, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,         0, 1, 32'h11,        1, 0, 32'h0,         1, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h200,       32'h11);
    // redirect in IDLE suppresses the request; then wrap at the top of memory
    add(0, 0, 1, 32'hFFFFFFFF,  0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,         1, 0, 32'h0,         1, 1, 32'hFFFFFFFC,  1, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,         0, 1, 32'h22,        1, 0, 32'h0,         1, 32'h0,         32'h0);
    add(0, 1, 0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h0,         0, 32'hFFFFFFFC,  32'h22);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h0,         0, 32'hFFFFFFFC,  32'h22);
    add(0, 0, 0, 32'h0,         1, 0, 32'h0,         1, 1, 32'h0,         1, 32'h0,         32'h0);
    // reset while waiting, then a stray rvalid
    add(1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,         0, 1, 32'hBEEF,      1, 1, 32'h0,         1, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,         1, 0, 32'h0,         1, 1, 32'h0,         1, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,         0, 1, 32'h33,        1, 0, 32'h0,         1, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         32'h33);
    add(0, 0, 0, 32'h0,         1, 0, 32'h0,         1, 1, 32'h4,         1, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,         0, 1, 32'h44,        1, 0, 32'h0,         1, 32'h0,         32'h0);
    // redirect in READY overrides stall and clears the outputs
    add(0, 1, 1, 32'h40,        0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h4,         32'h44);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 1, 32'h40,        1, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 1, 32'h40,        1, 32'h0,         32'h0);

    foreach (vecs[i]) begin
      logic        e_req;
      logic [31:0] e_addr;
      @(negedge CLK);
      RST = vecs[i].rst; stall = '0; stall[1] = vecs[i].s1;
      jmp_flag = vecs[i].jmp; jmp_target = vecs[i].jt;
      mem_gnt = vecs[i].gnt; mem_rvalid = vecs[i].rv; mem_rdata = vecs[i].rd;
      #2;
      e_req  = vecs[i].req;
      e_addr = vecs[i].addr;
`ifdef IF_FETCH_PREFETCH_EN
      if (!vecs[i].sreq && !vecs[i].s1 && !vecs[i].jmp) begin
        e_req  = 1'b1;
        e_addr = vecs[i].ipc + 32'd4;
      end
`endif
      if (vecs[i].chk) begin
        check($sformatf("row%0d mem_req", i), mem_req, e_req);
        if (e_req) check($sformatf("row%0d mem_addr", i), mem_addr, e_addr);
        check($sformatf("row%0d stallreq_if", i), stallreq_if, vecs[i].sreq);
        check($sformatf("row%0d if_pc", i), if_pc, vecs[i].ipc);
        check($sformatf("row%0d if_inst", i), if_inst, vecs[i].iinst);
      end
    end

`ifdef IF_FETCH_PREFETCH_EN
    // Back-to-back fetches: immediate gnt, rvalid one cycle later.
    @(negedge CLK);
    RST = 1'b1; stall = '0; jmp_flag = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    pend = 1'b0; pend_addr = '0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc != 0) @(negedge CLK);
      mem_rvalid = pend;
      mem_rdata  = mem_word(pend_addr);
      #1;
      mem_gnt = mem_req;
      #1;
      if (mem_gnt) pf_addrs.push_back(mem_addr);
      if (!stallreq_if) pf_pres.push_back(cyc);
      pend      = mem_gnt;
      pend_addr = mem_addr;
    end
    if (pf_addrs.size() < 3 || pf_pres.size() < 3) begin
      n_chk++; n_fail++;
      $display("FAIL prefetch progress: got %0d fetches %0d instructions expected >=3 each",
               pf_addrs.size(), pf_pres.size());
    end else begin
      check("prefetch addr0", pf_addrs[0], 32'h0);
      check("prefetch addr1", pf_addrs[1], 32'h4);
      check("prefetch addr2", pf_addrs[2], 32'h8);
      check("prefetch gap1", pf_pres[1] - pf_pres[0], 32'd2);
      check("prefetch gap2", pf_pres[2] - pf_pres[1], 32'd2);
    end
`endif

    // Randomized run against the PC-stream model.
    @(negedge CLK);
    RST = 1'b1; stall = '0; jmp_flag = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    exp_pc = 32'h0; outst = 1'b0; lat = 0; stuck = 0; presented = 0; out_addr = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge CLK);
      stall      = 6'($urandom);
      stall[1]   = ($urandom % 5) < 2;
      jmp_flag   = ($urandom % 14) == 0;
      jmp_target = $urandom;
      if (outst && lat == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(out_addr);
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (outst) lat--;
      end
      #1;
      mem_gnt = mem_req && !outst && (($urandom % 3) != 0);
      #1;
      if (!stallreq_if) begin
        check("rnd if_pc", if_pc, exp_pc);
        check("rnd if_inst", if_inst, mem_word(exp_pc));
        presented++;
        stuck = 0;
      end else begin
        check("rnd bubble if_pc", if_pc, 32'h0);
        check("rnd bubble if_inst", if_inst, 32'h0);
        stuck++;
      end
      if (jmp_flag) check("rnd req during redirect", mem_req, 1'b0);
      if (outst) check("rnd req while outstanding", mem_req, 1'b0);
      if (mem_gnt) begin
        exp_addr = (!stallreq_if && !stall[1]) ? exp_pc + 32'd4 : exp_pc;
        check("rnd fetch addr", mem_addr, exp_addr);
      end
      if (stuck > 60) begin
        n_chk++; n_fail++;
        $display("FAIL rnd progress: got %0d cycles without an instruction expected <=60", stuck);
        break;
      end
      if (mem_rvalid) outst = 1'b0;
      if (mem_gnt) begin
        outst    = 1'b1;
        out_addr = mem_addr;
        lat      = $urandom_range(0, 3);
      end
      if (jmp_flag) exp_pc = {jmp_target[31:2], 2'b00};
      else if (!stallreq_if && !stall[1]) exp_pc = exp_pc + 32'd4;
    end
    check("rnd instructions presented", 32'(presented > 100), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
